// File: rtl/pic_cycle_ctrl_if.sv
// Bundle between the PIC cycle sequencer and its environment:
// instruction/flag inputs, ROM fetch handshake, phase and write strobes.
interface pic_cycle_ctrl_if #(
    parameter int PC_W = 9
);
    logic [11:0]     inst;
    logic            aluz;
    logic            bit_tst;
    logic            rom_ack;
    logic [PC_W-1:0] rom_addr;
    logic            rom_req;
    logic [1:0]      q;
    logic            w_we;
    logic            f_we;
    logic            tris_we;
    logic            status_z_we;
    logic            status_c_we;
    logic            skip;

    modport master (
        input  inst, aluz, bit_tst, rom_ack,
        output rom_addr, rom_req, q, w_we, f_we, tris_we,
        output status_z_we, status_c_we, skip
    );

    modport slave (
        output inst, aluz, bit_tst, rom_ack,
        input  rom_addr, rom_req, q, w_we, f_we, tris_we,
        input  status_z_we, status_c_we, skip
    );
endinterface

// File: rtl/pic_cycle_ctrl.sv
// PIC-12 instruction-cycle sequencer: Q1..Q4 phases, PC, 2-level stack, strobes.
// Optional ROM_WAIT_EN: Q4 stalls until rom_ack.
module pic_cycle_ctrl #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(9'h1FF)
) (
    input  logic               clk4,
    input  logic               reset,
    pic_cycle_ctrl_if.master   bus
);
    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } phase_e;

    phase_e          q_q, q_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] stk0_q, stk0_d;
    logic [PC_W-1:0] stk1_q, stk1_d;
    logic            skip_q, skip_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] pc_inc;

    logic [3:0] opc;
    logic       d_bit;
    logic       dw, df, dt, dz, dc;
    logic       skip_nxt, push, pop, ld_goto;
    logic       ack_ok, adv, en;

    assign opc   = bus.inst[9:6];
    assign d_bit = bus.inst[5];

    always_comb begin
        dw       = 1'b0;
        df       = 1'b0;
        dt       = 1'b0;
        dz       = 1'b0;
        dc       = 1'b0;
        skip_nxt = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        ld_goto  = 1'b0;
        unique case (bus.inst[11:10])
            2'b00: begin
                if (opc == 4'h0) begin
                    df = d_bit;
                    // opc 0, d 0 leaves only inst[4:0]; TRIS is 5..7
                    dt = !d_bit && (bus.inst[4:0] >= 5'd5)
                                && (bus.inst[4:0] <= 5'd7);
                end else begin
                    df = d_bit;
                    dw = !d_bit;
                end
                dz = (opc >= 4'h1) && (opc <= 4'hA);
                dc = (opc == 4'h2) || (opc == 4'h7)
                  || (opc == 4'hC) || (opc == 4'hD);
                skip_nxt = ((opc == 4'hB) || (opc == 4'hF)) && bus.aluz;
            end
            2'b01: begin
                df       = !bus.inst[9];
                skip_nxt = bus.inst[9] & (bus.inst[8] ~^ bus.bit_tst);
            end
            2'b10: begin
                skip_nxt = 1'b1;
                ld_goto  = bus.inst[9];
                push     = (bus.inst[9:8] == 2'b01);
                pop      = (bus.inst[9:8] == 2'b00);
                dw       = pop;
            end
            2'b11: begin
                dw = 1'b1;
                dz = (bus.inst[9:8] != 2'b00);
            end
        endcase
    end

`ifdef ROM_WAIT_EN
    assign ack_ok = bus.rom_ack;
`else
    logic unused_ack;
    assign unused_ack = bus.rom_ack;
    assign ack_ok     = 1'b1;
`endif

    assign adv    = (q_q == Q4) && ack_ok;
    assign en     = (q_q == Q4) && !skip_q;
    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        q_d    = q_q;
        pc_d   = pc_q;
        stk0_d = stk0_q;
        stk1_d = stk1_q;
        skip_d = skip_q;
        if (q_q != Q4) begin
            q_d = phase_e'(q_q + 2'd1);
        end else if (adv) begin
            q_d    = Q1;
            pc_d   = pc_inc;
            skip_d = 1'b0;
            // a forced NOP only advances the PC
            if (!skip_q) begin
                skip_d = skip_nxt;
                if (ld_goto) begin
                    pc_d = PC_W'(bus.inst[8:0]);
                end else if (push) begin
                    pc_d   = PC_W'(bus.inst[7:0]);
                    stk1_d = stk0_q;
                    stk0_d = pc_inc;
                end else if (pop) begin
                    pc_d   = stk0_q;
                    stk0_d = stk1_q;
                end
            end
        end
        req_d = (q_d == Q4);
    end

    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            q_q    <= Q1;
            pc_q   <= RESET_VEC;
            stk0_q <= '0;
            stk1_q <= '0;
            skip_q <= 1'b1;
            req_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            pc_q   <= pc_d;
            stk0_q <= stk0_d;
            stk1_q <= stk1_d;
            skip_q <= skip_d;
            req_q  <= req_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.rom_addr    = pc_q;
    assign bus.rom_req     = req_q;
    assign bus.skip        = skip_q;
    assign bus.w_we        = en & dw;
    assign bus.f_we        = en & df;
    assign bus.tris_we     = en & dt;
    assign bus.status_z_we = en & dz;
    assign bus.status_c_we = en & dc;
endmodule

// File: tb/tb_pic_cycle_ctrl.sv
// Bench for pic_cycle_ctrl: directed sequences plus random instructions
// against an instruction-level reference model.
module tb_pic_cycle_ctrl;
    localparam int PC_W = 9;
    localparam int MSK  = (1 << PC_W) - 1;
    localparam logic [15:0] ZMASK = 16'h07FE;
    localparam logic [15:0] CMASK = 16'h3084;

    logic clk4  = 1'b0;
    logic reset = 1'b1;

    pic_cycle_ctrl_if #(.PC_W(PC_W)) bus ();

    pic_cycle_ctrl #(.PC_W(PC_W), .RESET_VEC(9'h1FF)) dut (
        .clk4 (clk4),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk4 = ~clk4;

    int n_cmp = 0;
    int n_bad = 0;

    int   m_pc, m_s0, m_s1;
    logic m_skip;
    logic [4:0] q4_st;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] dut_st();
        return {bus.w_we, bus.f_we, bus.tris_we,
                bus.status_z_we, bus.status_c_we};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 'h1FF;
        m_s0   = 0;
        m_s1   = 0;
        m_skip = 1'b1;
    endtask

    // kind: 0 sequential, 1 goto, 2 call, 3 retlw; st = {w,f,tris,z,c}
    task automatic decode(input logic [11:0] i, input logic az,
                          input logic bt, output logic [4:0] st,
                          output logic sk, output int kind);
        logic [3:0] opc;
        opc  = i[9:6];
        st   = '0;
        sk   = 1'b0;
        kind = 0;
        case (i[11:10])
            2'b00: begin
                if (i[5])                              st[3] = 1'b1;
                else if (opc != 0)                     st[4] = 1'b1;
                else if (i >= 12'h005 && i <= 12'h007) st[2] = 1'b1;
                st[1] = ZMASK[opc];
                st[0] = CMASK[opc];
                if (opc == 4'd11 || opc == 4'd15) sk = az;
            end
            2'b01: begin
                if (!i[9])     st[3] = 1'b1;
                else if (i[8]) sk = bt;
                else           sk = !bt;
            end
            2'b10: begin
                sk = 1'b1;
                if (i[9])      kind = 1;
                else if (i[8]) kind = 2;
                else begin
                    kind  = 3;
                    st[4] = 1'b1;
                end
            end
            default: begin
                st[4] = 1'b1;
                st[1] = (i[9:8] != 2'b00);
            end
        endcase
    endtask

    task automatic sample(input int p, input logic [4:0] st);
        @(negedge clk4);
        chk("q", bus.q, p);
        chk("rom_addr", bus.rom_addr, m_pc);
        chk("rom_req", bus.rom_req, (p == 3));
        chk("skip", bus.skip, m_skip);
        chk("strobes", dut_st(), (p == 3) ? st : 5'b0);
        if (p == 3) q4_st = dut_st();
    endtask

    // entered just after the edge that starts Q1
    task automatic run_cycle(input logic [11:0] i, input logic az,
                             input logic bt, input int abort_p);
        logic [4:0] st;
        logic       sk;
        int         kind;
        int         pc1;
`ifdef ROM_WAIT_EN
        int         w;
`endif
        decode(i, az, bt, st, sk, kind);
        if (m_skip) begin
            st   = '0;
            sk   = 1'b0;
            kind = 0;
        end
        bus.inst    = i;
        bus.aluz    = az;
        bus.bit_tst = bt;
        for (int p = 0; p < 4; p++) begin
            bus.rom_ack = 1'($urandom);
            if (p == abort_p) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_q", bus.q, 0);
                chk("abort_pc", bus.rom_addr, 'h1FF);
                chk("abort_skip", bus.skip, 1);
                chk("abort_req", bus.rom_req, 0);
                chk("abort_st", dut_st(), 0);
                @(posedge clk4);
                #1 reset = 1'b0;
                model_reset();
                return;
            end
`ifdef ROM_WAIT_EN
            if (p == 3) begin
                w = $urandom_range(0, 3);
                for (int k = 0; k < w; k++) begin
                    bus.rom_ack = 1'b0;
                    sample(p, st);
                    @(posedge clk4);
                    #1;
                end
                bus.rom_ack = 1'b1;
            end
`endif
            sample(p, st);
            @(posedge clk4);
            #1;
        end
        pc1 = (m_pc + 1) & MSK;
        case (kind)
            1: m_pc = i[8:0];
            2: begin
                m_s1 = m_s0;
                m_s0 = pc1;
                m_pc = i[7:0];
            end
            3: begin
                m_pc = m_s0;
                m_s0 = m_s1;
            end
            default: m_pc = pc1;
        endcase
        m_skip = sk;
    endtask

    initial begin
        logic [11:0] ri;
        int          ab;
        bus.inst    = '0;
        bus.aluz    = 1'b0;
        bus.bit_tst = 1'b0;
        bus.rom_ack = 1'b0;
        model_reset();

        @(negedge clk4);
        chk("rst_q", bus.q, 0);
        chk("rst_addr", bus.rom_addr, 'h1FF);
        chk("rst_skip", bus.skip, 1);
        chk("rst_req", bus.rom_req, 0);
        chk("rst_st", dut_st(), 0);
        @(posedge clk4);
        #1 reset = 1'b0;

        run_cycle(12'h1E8, 1'b0, 1'b0, -1);
        chk("lit_nop_st", q4_st, 5'b00000);
        chk("lit_wrap", bus.rom_addr, 'h000);
        run_cycle(12'h1E8, 1'b0, 1'b0, -1);
        chk("lit_addwf", q4_st, 5'b01011);
        run_cycle(12'hC55, 1'b0, 1'b0, -1);
        chk("lit_movlw", q4_st, 5'b10000);
        run_cycle(12'h2E0, 1'b1, 1'b0, -1);
        chk("lit_decfsz_skip", bus.skip, 1);
        run_cycle(12'hC55, 1'b0, 1'b0, -1);
        chk("lit_skipped_st", q4_st, 5'b00000);
        chk("lit_pc_seq", bus.rom_addr, 'h004);

        run_cycle(12'hA0F, 1'b0, 1'b0, -1);
        run_cycle(12'h000, 1'b0, 1'b0, -1);
        chk("lit_pc10", bus.rom_addr, 'h010);
        run_cycle(12'h920, 1'b0, 1'b0, -1);
        chk("lit_call20", bus.rom_addr, 'h020);
        run_cycle(12'h000, 1'b0, 1'b0, -1);
        run_cycle(12'h940, 1'b0, 1'b0, -1);
        run_cycle(12'h000, 1'b0, 1'b0, -1);
        run_cycle(12'h960, 1'b0, 1'b0, -1);
        run_cycle(12'h000, 1'b0, 1'b0, -1);
        run_cycle(12'h8AA, 1'b0, 1'b0, -1);
        chk("lit_ret1", bus.rom_addr, 'h042);
        chk("lit_retlw_st", q4_st, 5'b10000);
        run_cycle(12'h000, 1'b0, 1'b0, -1);
        run_cycle(12'h8AA, 1'b0, 1'b0, -1);
        chk("lit_ret2", bus.rom_addr, 'h022);
        run_cycle(12'h000, 1'b0, 1'b0, -1);
        run_cycle(12'h8AA, 1'b0, 1'b0, -1);
        chk("lit_ret3", bus.rom_addr, 'h022);
        run_cycle(12'h000, 1'b0, 1'b0, -1);

        run_cycle(12'hBFF, 1'b0, 1'b0, -1);
        chk("lit_goto_pc", bus.rom_addr, 'h1FF);
        chk("lit_goto_skip", bus.skip, 1);
        run_cycle(12'h1E8, 1'b0, 1'b0, -1);
        chk("lit_goto_wrap", bus.rom_addr, 'h000);
        chk("lit_goto_nop", q4_st, 5'b00000);

        for (int n = 0; n < 500; n++) begin
            ri = 12'($urandom);
            if ($urandom_range(0, 7) == 0)
                ri = 12'(5 + $urandom_range(0, 2));
            ab = ($urandom_range(0, 39) == 0) ? $urandom_range(0, 3) : -1;
            run_cycle(ri, 1'($urandom), 1'($urandom), ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
